// File: rtl/flag_hazard_ctrl.sv
// Flag-dependency stall and branch-flush sequencer for flag-predicated execution.
// Optional macro FLAG_FWD_EN: Execute flags forwarded to Decode, so the stall is one cycle shorter.
module flag_hazard_ctrl #(
    parameter int FLAG_LAT = 2,
    parameter int BR_PEN   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       validd,
    input  logic [3:0] condd,
    input  logic [1:0] flagwd,
    input  logic       pcsrce,
    input  logic       stallext,
    output logic       stallf,
    output logic       stalld,
    output logic       flushd,
    output logic       flushe,
    output logic       pendnz,
    output logic       pendcv
);

    localparam int CW = (FLAG_LAT < 1) ? 1 : $clog2(FLAG_LAT + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(FLAG_LAT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = '0;
    // fc is two bits wide, so BR_PEN above 4 wraps the reload value.
    localparam logic [1:0]    FC_LOAD  = 2'(BR_PEN - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t        state;
    logic [1:0]    fc;
    logic [CW-1:0] cnt_nz;
    logic [CW-1:0] cnt_cv;

    logic [1:0] mask;
    logic       busy_nz;
    logic       busy_cv;
    logic       hazard;
    logic       stall_i;
    logic       flushd_i;
    logic       flushe_i;
    logic       issue;

    // Condition field to flag groups read: bit 1 = NZ, bit 0 = CV.
    always_comb begin
        mask = 2'b11;
        case (condd)
            4'b0000, 4'b0001, 4'b0100, 4'b0101: mask = 2'b10;
            4'b0010, 4'b0011, 4'b0110, 4'b0111: mask = 2'b01;
            4'b1110, 4'b1111:                   mask = 2'b00;
            default:                            mask = 2'b11;
        endcase
    end

`ifdef FLAG_FWD_EN
    assign busy_nz = (cnt_nz > CNT_ONE);
    assign busy_cv = (cnt_cv > CNT_ONE);
`else
    assign busy_nz = (cnt_nz != CNT_ZERO);
    assign busy_cv = (cnt_cv != CNT_ZERO);
`endif

    assign hazard   = validd & |(mask & {busy_nz, busy_cv});
    // A taken branch wins over a flag hazard: the dependent instruction is flushed anyway.
    assign stall_i  = (hazard & (state == IDLE) & ~pcsrce) | stallext;
    assign flushd_i = ~stallext & (pcsrce | (state == FLUSH));
    assign flushe_i = ~stallext & (hazard | pcsrce);
    assign issue    = validd & ~stall_i & ~flushd_i & ~stallext;

    assign stallf = stall_i & ~reset;
    assign stalld = stall_i & ~reset;
    assign flushd = flushd_i & ~reset;
    assign flushe = flushe_i & ~reset;
    assign pendnz = (cnt_nz != CNT_ZERO) & ~reset;
    assign pendcv = (cnt_cv != CNT_ZERO) & ~reset;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_nz <= CNT_ZERO;
        end else if (stallext) begin
            cnt_nz <= cnt_nz;
        end else if (issue && flagwd[1]) begin
            cnt_nz <= CNT_LOAD;
        end else if (cnt_nz != CNT_ZERO) begin
            cnt_nz <= cnt_nz - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_cv <= CNT_ZERO;
        end else if (stallext) begin
            cnt_cv <= cnt_cv;
        end else if (issue && flagwd[0]) begin
            cnt_cv <= CNT_LOAD;
        end else if (cnt_cv != CNT_ZERO) begin
            cnt_cv <= cnt_cv - CNT_ONE;
        end
    end

    // Branch flush sequencer; the PCSrcE cycle itself is flushed from IDLE,
    // FLUSH covers the remaining BR_PEN-1 cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            fc    <= 2'd0;
        end else if (!stallext) begin
            case (state)
                IDLE: begin
                    if (pcsrce && (BR_PEN > 1)) begin
                        state <= FLUSH;
                        fc    <= FC_LOAD;
                    end
                end
                FLUSH: begin
                    if (pcsrce) begin
                        fc <= FC_LOAD;
                    end else begin
                        fc <= fc - 2'd1;
                        if (fc <= 2'd1) begin
                            state <= IDLE;
                            fc    <= 2'd0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    fc    <= 2'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flag_hazard_ctrl.sv
// Bench for flag_hazard_ctrl: directed vector table, reset corner case, then random
// stimulus against a timestamp-based model (FLAG_FWD_EN selects the forwarding variant).
module tb_flag_hazard_ctrl;

    localparam int FLAG_LAT = 2;
    localparam int BR_PEN   = 2;

    logic       clk;
    logic       reset;
    logic       validd;
    logic [3:0] condd;
    logic [1:0] flagwd;
    logic       pcsrce;
    logic       stallext;
    logic       stallf;
    logic       stalld;
    logic       flushd;
    logic       flushe;
    logic       pendnz;
    logic       pendcv;

    int n_checks = 0;
    int n_errors = 0;

    flag_hazard_ctrl #(.FLAG_LAT(FLAG_LAT), .BR_PEN(BR_PEN)) dut (
        .clk      (clk),
        .reset    (reset),
        .validd   (validd),
        .condd    (condd),
        .flagwd   (flagwd),
        .pcsrce   (pcsrce),
        .stallext (stallext),
        .stallf   (stallf),
        .stalld   (stalld),
        .flushd   (flushd),
        .flushe   (flushe),
        .pendnz   (pendnz),
        .pendcv   (pendcv)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // rst pulses reset before the row; e = {stallf, stalld, flushd, flushe, pendnz, pendcv}
    typedef struct packed {
        logic       rst;
        logic       v;
        logic [3:0] c;
        logic [1:0] w;
        logic       p;
        logic       s;
        logic [5:0] e;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic v, input logic [3:0] c, input logic [1:0] w,
                       input logic p, input logic s, input logic [5:0] e);
        vec_t r;
        r.rst = rst; r.v = v; r.c = c; r.w = w; r.p = p; r.s = s; r.e = e;
        vecs.push_back(r);
    endtask

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [5:0] e);
        chk({tag, "_stallf"}, stallf, e[5]);
        chk({tag, "_stalld"}, stalld, e[4]);
        chk({tag, "_flushd"}, flushd, e[3]);
        chk({tag, "_flushe"}, flushe, e[2]);
        chk({tag, "_pendnz"}, pendnz, e[1]);
        chk({tag, "_pendcv"}, pendcv, e[0]);
    endtask

    task automatic drive(input logic v, input logic [3:0] c, input logic [1:0] w,
                         input logic p, input logic s);
        validd = v; condd = c; flagwd = w; pcsrce = p; stallext = s;
    endtask

    // Pulse lasts 2 time units inside the drive phase, no clock edge involved.
    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        reset = 1'b0;
    endtask

    // Reference model: time advances only on cycles without StallExt. A flag write
    // issued at active time t is outstanding until t+1+FLAG_LAT; a branch at time t
    // keeps Decode flushed up to (but not including) time t+BR_PEN.
    int now_t, ready_nz, ready_cv, flush_end;
    logic m_stall, m_flushd, m_flushe, m_pnz, m_pcv;

    function automatic logic [1:0] reads_of(input logic [3:0] c);
        int ci;
        ci = int'(c);
        if (ci >= 14) return 2'b00;
        if (ci >= 8)  return 2'b11;
        return ((ci % 4) >= 2) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic is_busy(input int remaining);
`ifdef FLAG_FWD_EN
        return remaining > 1;
`else
        return remaining > 0;
`endif
    endfunction

    task automatic model_reset();
        ready_nz  = now_t;
        ready_cv  = now_t;
        flush_end = now_t;
    endtask

    task automatic model_eval();
        int rn, rc;
        logic in_flush, haz;
        logic [1:0] rd;
        rn = (ready_nz > now_t) ? ready_nz - now_t : 0;
        rc = (ready_cv > now_t) ? ready_cv - now_t : 0;
        rd = reads_of(condd);
        in_flush = (now_t < flush_end);
        haz = validd && ((rd[1] && is_busy(rn)) || (rd[0] && is_busy(rc)));
        m_stall  = (haz && !in_flush && !pcsrce) || stallext;
        m_flushd = !stallext && (pcsrce || in_flush);
        m_flushe = !stallext && (haz || pcsrce);
        m_pnz    = rn > 0;
        m_pcv    = rc > 0;
    endtask

    task automatic model_step();
        if (!stallext) begin
            if (validd && !m_stall && !m_flushd) begin
                if (flagwd[1]) ready_nz = now_t + 1 + FLAG_LAT;
                if (flagwd[0]) ready_cv = now_t + 1 + FLAG_LAT;
            end
            if (pcsrce) flush_end = now_t + BR_PEN;
            now_t++;
        end
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b1, 4'b0000, 2'b11, 1'b1, 1'b1);
        #2;
        chk_all("reset_state", 6'b000000);
        @(posedge clk); #1;
        reset = 1'b0;
        drive(1'b0, 4'b1110, 2'b00, 1'b0, 1'b0);

        // T1: CMP then dependent BEQ
        add(1, 1, 4'b1110, 2'b11, 0, 0, 6'b000000);
        add(0, 1, 4'b0000, 2'b00, 0, 0, 6'b110111);
`ifdef FLAG_FWD_EN
        add(0, 1, 4'b0000, 2'b00, 0, 0, 6'b000011);
`else
        add(0, 1, 4'b0000, 2'b00, 0, 0, 6'b110111);
`endif
        add(0, 1, 4'b0000, 2'b00, 0, 0, 6'b000000);
        // T2: only CV pending, NZ reader then CV reader
        add(1, 1, 4'b1110, 2'b01, 0, 0, 6'b000000);
        add(0, 1, 4'b0000, 2'b00, 0, 0, 6'b000001);
        add(0, 1, 4'b0000, 2'b00, 0, 0, 6'b000001);
        add(0, 1, 4'b0000, 2'b00, 0, 0, 6'b000000);
        add(1, 1, 4'b1110, 2'b01, 0, 0, 6'b000000);
        add(0, 1, 4'b0010, 2'b00, 0, 0, 6'b110101);
`ifdef FLAG_FWD_EN
        add(0, 1, 4'b0010, 2'b00, 0, 0, 6'b000001);
`else
        add(0, 1, 4'b0010, 2'b00, 0, 0, 6'b110101);
`endif
        add(0, 1, 4'b0010, 2'b00, 0, 0, 6'b000000);
        // T3: unconditional after flag write
        add(1, 1, 4'b1110, 2'b11, 0, 0, 6'b000000);
        add(0, 1, 4'b1110, 2'b00, 0, 0, 6'b000011);
        add(0, 1, 4'b1110, 2'b00, 0, 0, 6'b000011);
        add(0, 1, 4'b1110, 2'b00, 0, 0, 6'b000000);
        // T4: branch concurrent with hazard, then a plain branch
        add(1, 1, 4'b1110, 2'b11, 0, 0, 6'b000000);
        add(0, 1, 4'b0000, 2'b00, 1, 0, 6'b001111);
`ifdef FLAG_FWD_EN
        add(0, 1, 4'b0000, 2'b00, 0, 0, 6'b001011);
`else
        add(0, 1, 4'b0000, 2'b00, 0, 0, 6'b001111);
`endif
        add(0, 0, 4'b0000, 2'b00, 0, 0, 6'b000000);
        add(1, 0, 4'b1110, 2'b00, 1, 0, 6'b001100);
        add(0, 0, 4'b1110, 2'b00, 0, 0, 6'b001000);
        add(0, 0, 4'b1110, 2'b00, 0, 0, 6'b000000);
        // T5: StallExt freezes counters mid-hazard
        add(1, 1, 4'b1110, 2'b11, 0, 0, 6'b000000);
        add(0, 1, 4'b0000, 2'b00, 0, 1, 6'b110011);
        add(0, 1, 4'b0000, 2'b00, 0, 1, 6'b110011);
        add(0, 1, 4'b0000, 2'b00, 0, 1, 6'b110011);
        add(0, 1, 4'b0000, 2'b00, 0, 0, 6'b110111);
`ifdef FLAG_FWD_EN
        add(0, 1, 4'b0000, 2'b00, 0, 0, 6'b000011);
`else
        add(0, 1, 4'b0000, 2'b00, 0, 0, 6'b110111);
`endif
        add(0, 1, 4'b0000, 2'b00, 0, 0, 6'b000000);
        // StallExt inside FLUSH, then branch restart inside FLUSH
        add(1, 0, 4'b1110, 2'b00, 1, 0, 6'b001100);
        add(0, 0, 4'b1110, 2'b00, 0, 1, 6'b110000);
        add(0, 0, 4'b1110, 2'b00, 0, 0, 6'b001000);
        add(0, 0, 4'b1110, 2'b00, 0, 0, 6'b000000);
        add(1, 0, 4'b1110, 2'b00, 1, 0, 6'b001100);
        add(0, 0, 4'b1110, 2'b00, 1, 0, 6'b001100);
        add(0, 0, 4'b1110, 2'b00, 0, 0, 6'b001000);
        add(0, 0, 4'b1110, 2'b00, 0, 0, 6'b000000);

        foreach (vecs[i]) begin
            if (vecs[i].rst) pulse_reset();
            drive(vecs[i].v, vecs[i].c, vecs[i].w, vecs[i].p, vecs[i].s);
            @(negedge clk);
            chk_all($sformatf("row%0d", i), vecs[i].e);
            @(posedge clk); #1;
        end

        // T6: reset asserted in the middle of a stall, no clock edge
        pulse_reset();
        drive(1'b1, 4'b1110, 2'b11, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 4'b0000, 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        chk_all("t6_pre", 6'b110111);
        @(posedge clk); #1;
        stallext = 1'b1;
        reset = 1'b1;
        #1;
        chk_all("t6_inreset", 6'b000000);
        #1;
        reset = 1'b0;
        stallext = 1'b0;
        @(negedge clk);
        chk_all("t6_after", 6'b000000);
        @(posedge clk); #1;

        // Random phase against the model
        pulse_reset();
        now_t = 0;
        model_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulse_reset();
                model_reset();
            end
            drive($urandom_range(0, 9) < 8, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                  $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
            @(negedge clk);
            model_eval();
            chk_all($sformatf("rnd%0d", cyc), {m_stall, m_stall, m_flushd, m_flushe, m_pnz, m_pcv});
            model_step();
            @(posedge clk); #1;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
